// File: rtl/core_bram_dual_port_pipelined.sv
// +----------------------------------------------------------------------------+
// | core_bram_dual_port_pipelined: true dual-port byte-enabled BRAM with      |
// | 1/2-cycle read latency, collision resolution and an in-band zero-fill.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module core_bram_dual_port_pipelined #(
  parameter int DataWidth   = 16,
  parameter int ByteWidth   = 8,
  parameter int Depth       = 8,
  parameter int ReadLatency = 1,
  parameter int ReadFirst   = 0,
  localparam int AddrWidth  = $clog2(Depth),
  localparam int Lanes      = DataWidth / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 a_en_i,
  input  logic                 a_write_en_i,
  input  logic [Lanes-1:0]     a_byte_en_i,
  input  logic [AddrWidth-1:0] a_addr_i,
  input  logic [DataWidth-1:0] a_data_i,
  output logic [DataWidth-1:0] a_data_o,
  output logic                 a_valid_o,
  input  logic                 b_en_i,
  input  logic                 b_write_en_i,
  input  logic [Lanes-1:0]     b_byte_en_i,
  input  logic [AddrWidth-1:0] b_addr_i,
  input  logic [DataWidth-1:0] b_data_i,
  output logic [DataWidth-1:0] b_data_o,
  output logic                 b_valid_o,
  input  logic                 clear_i,
  output logic                 busy_o,
  output logic                 collision_o,
  input  logic                 assert_on_i
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam logic [AddrWidth:0]   DepthW   = (AddrWidth + 1)'(Depth);
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(Depth - 1);

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] clr_cnt_q, clr_cnt_d;
  logic [DataWidth-1:0] mem_q [Depth];

  logic                 a_acc, b_acc, a_oor, b_oor, a_wr, b_wr, coll_d;
  logic [DataWidth-1:0] a_old, b_old, a_rd_d, b_rd_d;
  logic                 a_valid1_q, b_valid1_q, collision_q;
  logic [DataWidth-1:0] a_data1_q, b_data1_q;

  function automatic logic [DataWidth-1:0] merge_lanes(
    input logic [DataWidth-1:0] old_word,
    input logic [DataWidth-1:0] new_word,
    input logic [Lanes-1:0]     lane_en
  );
    logic [DataWidth-1:0] res;
    res = old_word;
    for (int l = 0; l < Lanes; l++) begin
      if (lane_en[l]) res[l*ByteWidth +: ByteWidth] = new_word[l*ByteWidth +: ByteWidth];
    end
    return res;
  endfunction

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      IDLE: begin
        if (clear_i) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        if (clr_cnt_q == LastAddr) state_d = IDLE;
        else clr_cnt_d = clr_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // clear_i wins over port traffic presented in the same cycle
  assign a_acc  = a_en_i && (state_q == IDLE) && !clear_i;
  assign b_acc  = b_en_i && (state_q == IDLE) && !clear_i;
  assign a_oor  = {1'b0, a_addr_i} >= DepthW;
  assign b_oor  = {1'b0, b_addr_i} >= DepthW;
  assign a_wr   = a_acc && a_write_en_i && !a_oor;
  assign b_wr   = b_acc && b_write_en_i && !b_oor;
  assign coll_d = a_acc && b_acc && (a_addr_i == b_addr_i) && (a_write_en_i || b_write_en_i);

  // Reads see pre-cycle contents; a writing port may fold in only its own lanes
  always_comb begin
    a_old  = a_oor ? '0 : mem_q[a_addr_i];
    b_old  = b_oor ? '0 : mem_q[b_addr_i];
    a_rd_d = a_old;
    b_rd_d = b_old;
    if (!a_oor && a_write_en_i && (ReadFirst == 0)) a_rd_d = merge_lanes(a_old, a_data_i, a_byte_en_i);
    if (!b_oor && b_write_en_i && (ReadFirst == 0)) b_rd_d = merge_lanes(b_old, b_data_i, b_byte_en_i);
  end

  // Port A is written last so it owns overlapping lanes on a shared address
  always_ff @(posedge clk_i) begin
    if (state_q == CLEAR) mem_q[clr_cnt_q] <= '0;
    for (int l = 0; l < Lanes; l++) begin
      if (b_wr && b_byte_en_i[l]) mem_q[b_addr_i][l*ByteWidth +: ByteWidth] <= b_data_i[l*ByteWidth +: ByteWidth];
      if (a_wr && a_byte_en_i[l]) mem_q[a_addr_i][l*ByteWidth +: ByteWidth] <= a_data_i[l*ByteWidth +: ByteWidth];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      clr_cnt_q   <= '0;
      a_valid1_q  <= 1'b0;
      b_valid1_q  <= 1'b0;
      a_data1_q   <= '0;
      b_data1_q   <= '0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      a_valid1_q  <= a_acc;
      b_valid1_q  <= b_acc;
      collision_q <= coll_d;
      if (a_acc) a_data1_q <= a_rd_d;
      if (b_acc) b_data1_q <= b_rd_d;
    end
  end

  generate
    if (ReadLatency == 2) begin : g_lat2
      logic                 a_valid2_q, b_valid2_q;
      logic [DataWidth-1:0] a_data2_q, b_data2_q;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          a_valid2_q <= 1'b0;
          b_valid2_q <= 1'b0;
          a_data2_q  <= '0;
          b_data2_q  <= '0;
        end else begin
          a_valid2_q <= a_valid1_q;
          b_valid2_q <= b_valid1_q;
          if (a_valid1_q) a_data2_q <= a_data1_q;
          if (b_valid1_q) b_data2_q <= b_data1_q;
        end
      end
      assign a_valid_o = a_valid2_q;
      assign b_valid_o = b_valid2_q;
      assign a_data_o  = a_data2_q;
      assign b_data_o  = b_data2_q;
    end else begin : g_lat1
      assign a_valid_o = a_valid1_q;
      assign b_valid_o = b_valid1_q;
      assign a_data_o  = a_data1_q;
      assign b_data_o  = b_data1_q;
    end
  endgenerate

  assign busy_o      = (state_q == CLEAR);
  assign collision_o = collision_q;

`ifdef ENABLE_SIMULATION_ASSERTS
  always_ff @(posedge clk_i) begin
    if (assert_on_i && a_acc && a_oor) $error("port A address %0d out of range", a_addr_i);
    if (assert_on_i && b_acc && b_oor) $error("port B address %0d out of range", b_addr_i);
  end
`else
  logic unused_assert_on;
  assign unused_assert_on = assert_on_i;
`endif

endmodule

`default_nettype wire

// File: tb/tb_core_bram_dual_port_pipelined.sv
// +----------------------------------------------------------------------------+
// | tb_core_bram_dual_port_pipelined: two configurations driven in lockstep   |
// | against an array-based reference model. Revision: 1.0                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_core_bram_dual_port_pipelined;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic        a_en, a_we, b_en, b_we, clr, aon;
  logic [1:0]  a_be, b_be;
  logic [2:0]  a_addr, b_addr;
  logic [15:0] a_din, b_din;

  logic [15:0] a_dout [2];
  logic [15:0] b_dout [2];
  logic        a_vo [2];
  logic        b_vo [2];
  logic        busy [2];
  logic        coll [2];

  core_bram_dual_port_pipelined #(
    .DataWidth(16), .ByteWidth(8), .Depth(8), .ReadLatency(1), .ReadFirst(0)
  ) u_dut0 (
    .clk_i(clk_i), .rst_i(rst_i),
    .a_en_i(a_en), .a_write_en_i(a_we), .a_byte_en_i(a_be), .a_addr_i(a_addr),
    .a_data_i(a_din), .a_data_o(a_dout[0]), .a_valid_o(a_vo[0]),
    .b_en_i(b_en), .b_write_en_i(b_we), .b_byte_en_i(b_be), .b_addr_i(b_addr),
    .b_data_i(b_din), .b_data_o(b_dout[0]), .b_valid_o(b_vo[0]),
    .clear_i(clr), .busy_o(busy[0]), .collision_o(coll[0]), .assert_on_i(aon)
  );

  core_bram_dual_port_pipelined #(
    .DataWidth(16), .ByteWidth(8), .Depth(6), .ReadLatency(2), .ReadFirst(1)
  ) u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i),
    .a_en_i(a_en), .a_write_en_i(a_we), .a_byte_en_i(a_be), .a_addr_i(a_addr),
    .a_data_i(a_din), .a_data_o(a_dout[1]), .a_valid_o(a_vo[1]),
    .b_en_i(b_en), .b_write_en_i(b_we), .b_byte_en_i(b_be), .b_addr_i(b_addr),
    .b_data_i(b_din), .b_data_o(b_dout[1]), .b_valid_o(b_vo[1]),
    .clear_i(clr), .busy_o(busy[1]), .collision_o(coll[1]), .assert_on_i(aon)
  );

  // Per-instance configuration mirrored in the model
  int dep [2] = '{8, 6};
  int lat [2] = '{1, 2};
  int rf  [2] = '{0, 1};

  int checks = 0;
  int errors = 0;

  logic [15:0] mm [2][8];
  int          busy_left [2];
  int          clr_ptr [2];
  logic        pv [2][2][3];
  logic [15:0] pd [2][2][3];
  logic        xv [2][2];
  logic [15:0] xd [2][2];
  logic        xcoll [2];

  function automatic logic [15:0] merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                        input logic [1:0] be);
    logic [15:0] r;
    r = old_w;
    if (be[0]) r[7:0]  = new_w[7:0];
    if (be[1]) r[15:8] = new_w[15:8];
    return r;
  endfunction

  task automatic model_reset(input int k);
    busy_left[k] = 0;
    clr_ptr[k]   = 0;
    xcoll[k]     = 1'b0;
    for (int p = 0; p < 2; p++) begin
      xv[k][p] = 1'b0;
      xd[k][p] = 16'h0;
      for (int s = 0; s < 3; s++) begin
        pv[k][p][s] = 1'b0;
        pd[k][p][s] = 16'h0;
      end
    end
  endtask

  task automatic model_step(input int k);
    logic        en [2];
    logic        we [2];
    logic        acc [2];
    logic [1:0]  be [2];
    int          ad [2];
    logic [15:0] din [2];
    logic [15:0] old [2];
    logic [15:0] res [2];
    en  = '{a_en, b_en};
    we  = '{a_we, b_we};
    be  = '{a_be, b_be};
    ad  = '{int'(a_addr), int'(b_addr)};
    din = '{a_din, b_din};
    acc = '{1'b0, 1'b0};
    if (busy_left[k] > 0) begin
      mm[k][clr_ptr[k]] = 16'h0;
      clr_ptr[k]++;
      busy_left[k]--;
    end else if (clr) begin
      busy_left[k] = dep[k];
      clr_ptr[k]   = 0;
    end else begin
      acc[0] = en[0];
      acc[1] = en[1];
    end
    for (int p = 0; p < 2; p++) begin
      old[p] = (ad[p] < dep[k]) ? mm[k][ad[p]] : 16'h0;
      res[p] = old[p];
      if (ad[p] < dep[k] && we[p] && rf[k] == 0) res[p] = merge(old[p], din[p], be[p]);
    end
    xcoll[k] = acc[0] && acc[1] && (ad[0] == ad[1]) && (we[0] || we[1]);
    for (int p = 1; p >= 0; p--) begin
      if (acc[p] && we[p] && ad[p] < dep[k]) mm[k][ad[p]] = merge(mm[k][ad[p]], din[p], be[p]);
    end
    for (int p = 0; p < 2; p++) begin
      pv[k][p][2] = pv[k][p][1];
      pd[k][p][2] = pd[k][p][1];
      pv[k][p][1] = acc[p];
      pd[k][p][1] = res[p];
      xv[k][p]    = pv[k][p][lat[k]];
      if (xv[k][p]) xd[k][p] = pd[k][p][lat[k]];
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("i%0d_a_valid", k), 16'(a_vo[k]), 16'(xv[k][0]));
      check($sformatf("i%0d_a_data", k), a_dout[k], xd[k][0]);
      check($sformatf("i%0d_b_valid", k), 16'(b_vo[k]), 16'(xv[k][1]));
      check($sformatf("i%0d_b_data", k), b_dout[k], xd[k][1]);
      check($sformatf("i%0d_busy", k), 16'(busy[k]), 16'(busy_left[k] > 0));
      check($sformatf("i%0d_collision", k), 16'(coll[k]), 16'(xcoll[k]));
    end
  endtask

  task automatic cycle();
    @(posedge clk_i);
    for (int k = 0; k < 2; k++) begin
      if (rst_i) model_reset(k);
      else model_step(k);
    end
    #1;
    compare_all();
    @(negedge clk_i);
  endtask

  task automatic idle();
    a_en = 0; a_we = 0; a_be = 0; a_addr = 0; a_din = 0;
    b_en = 0; b_we = 0; b_be = 0; b_addr = 0; b_din = 0;
    clr  = 0;
  endtask

  task automatic acc_a(input logic we, input logic [1:0] be, input logic [2:0] ad, input logic [15:0] d);
    a_en = 1; a_we = we; a_be = be; a_addr = ad; a_din = d;
  endtask

  task automatic acc_b(input logic we, input logic [1:0] be, input logic [2:0] ad, input logic [15:0] d);
    b_en = 1; b_we = we; b_be = be; b_addr = ad; b_din = d;
  endtask

  task automatic fill_all(input logic [15:0] d);
    for (int i = 0; i < 8; i++) begin
      idle(); acc_a(1, 2'b11, 3'(i), d); cycle();
    end
    idle();
  endtask

  initial begin
    int busy_cycles;
    idle();
    aon = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) mm[k][i] = 16'h0;
      model_reset(k);
    end
    repeat (2) @(negedge clk_i);
    compare_all();
    rst_i = 1'b0;

    fill_all(16'hFFFF);

    // Write then cross-port read
    acc_a(1, 2'b11, 3'd3, 16'hBEEF); cycle();
    idle(); acc_b(0, 2'b00, 3'd3, 16'h0); cycle();
    check("dir_beef_valid", 16'(b_vo[0]), 16'h1);
    check("dir_beef_data", b_dout[0], 16'hBEEF);
    idle(); cycle();
    check("dir_beef_lat2", b_dout[1], 16'hBEEF);

    // Same-port partial write, read-during-write
    acc_a(1, 2'b11, 3'd5, 16'h1234); cycle();
    idle(); acc_a(1, 2'b01, 3'd5, 16'hABCD); cycle();
    check("dir_merge_new", a_dout[0], 16'h12CD);
    idle(); cycle();
    check("dir_merge_old", a_dout[1], 16'h1234);
    acc_a(0, 2'b00, 3'd5, 16'h0); cycle();
    check("dir_merge_mem", a_dout[0], 16'h12CD);

    // Cross-port write collisions
    idle(); acc_a(1, 2'b11, 3'd2, 16'hAAAA); acc_b(1, 2'b11, 3'd2, 16'h5555); cycle();
    check("dir_coll_pulse", 16'(coll[0]), 16'h1);
    idle(); acc_a(0, 2'b00, 3'd2, 16'h0); cycle();
    check("dir_coll_full", a_dout[0], 16'hAAAA);
    check("dir_coll_end", 16'(coll[0]), 16'h0);
    idle(); acc_a(1, 2'b10, 3'd2, 16'hAAAA); acc_b(1, 2'b01, 3'd2, 16'h5555); cycle();
    idle(); acc_b(0, 2'b00, 3'd2, 16'h0); cycle();
    check("dir_coll_lanes", b_dout[0], 16'hAA55);

    // Full clear with reads attempted while busy
    fill_all(16'hFFFF);
    clr = 1; acc_a(0, 2'b00, 3'd1, 16'h0); cycle();
    idle();
    busy_cycles = 0;
    for (int i = 0; i < 20 && busy[0]; i++) begin
      busy_cycles++;
      acc_a(0, 2'b00, 3'($urandom_range(0, 7)), 16'h0);
      clr = (i == 2);
      cycle();
      idle();
    end
    check("dir_busy_len", 16'(busy_cycles), 16'd8);
    for (int i = 0; i < 8; i++) begin
      acc_a(0, 2'b00, 3'(i), 16'h0); cycle();
      check("dir_clear_zero", a_dout[0], 16'h0);
      idle();
    end

    // Reset in the middle of a clear
    fill_all(16'hFFFF);
    clr = 1; cycle();
    idle();
    repeat (4) cycle();
    rst_i = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) model_reset(k);
    check("dir_rst_busy", 16'(busy[0]), 16'h0);
    check("dir_rst_data", a_dout[0], 16'h0);
    compare_all();
    cycle();
    rst_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      acc_a(0, 2'b00, 3'(i), 16'h0); cycle();
      check("dir_partial_clear", a_dout[0], (i < 4) ? 16'h0 : 16'hFFFF);
      idle();
    end

    // Out-of-range on the 6-deep instance
    acc_a(1, 2'b11, 3'd7, 16'h7777); cycle();
    idle(); acc_a(0, 2'b00, 3'd7, 16'h0); cycle();
    idle(); cycle();
    check("dir_oor_valid", 16'(a_vo[1]), 16'h1);
    check("dir_oor_data", a_dout[1], 16'h0);
    check("dir_inrange_data", a_dout[0], 16'h7777);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      a_en = ($urandom_range(0, 3) != 0); a_we = 1'($urandom); a_be = 2'($urandom);
      a_addr = 3'($urandom); a_din = 16'($urandom);
      b_en = ($urandom_range(0, 3) != 0); b_we = 1'($urandom); b_be = 2'($urandom);
      b_addr = 3'($urandom); b_din = 16'($urandom);
      clr = ($urandom_range(0, 49) == 0);
      cycle();
    end
    idle();
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/core_bram_dual_port_pipelined.md
Name: core_bram_dual_port_pipelined

Overview:
Single-clock true dual-port block RAM with per-port byte enables, configurable read latency (1 or 2), configurable same-port read-during-write, and defined cross-port collision resolution. Adds an in-band clear sequencer that zeroes the whole array without external address generation. This is the general-purpose successor for the weight and activation buffers in the MNIST datapath.

Parameters:
DataWidth, 16, word width in bits; must be a multiple of ByteWidth
ByteWidth, 8, bits per byte-enable lane
Depth, 8, number of words; Depth >= 2, need not be a power of two
ReadLatency, 1, cycles from accepted access to data_o/valid_o; legal values 1 or 2
ReadFirst, 0, same-port write: 0 = data_o shows the merged new word, 1 = data_o shows the old word
(derived) AddrWidth = $clog2(Depth), Lanes = DataWidth/ByteWidth

Ports:
clk_i  in  1  clock; all logic on the rising edge
rst_i  in  1  asynchronous active-high reset
a_en_i  in  1  port A access request
a_write_en_i  in  1  port A write (qualified by a_en_i)
a_byte_en_i  in  Lanes  port A byte lane write mask
a_addr_i  in  AddrWidth  port A word address
a_data_i  in  DataWidth  port A write data
a_data_o  out  DataWidth  port A read data
a_valid_o  out  1  port A data_o valid strobe
b_en_i, b_write_en_i, b_byte_en_i, b_addr_i, b_data_i, b_data_o, b_valid_o  same widths and meaning for port B
clear_i  in  1  start a zero-fill of the full array
busy_o  out  1  clear in progress; port accesses are ignored
collision_o  out  1  same-address conflict strobe
assert_on_i  in  1  enables simulation asserts

Behaviour:
- Reset (asynchronous): a/b_data_o = 0, a/b_valid_o = 0, collision_o = 0, busy_o = 0; FSM goes to IDLE; all pipeline stages flushed. Array contents are not reset.
- Access acceptance: an access is accepted when en_i=1 and state is IDLE. With en_i=0, data_o holds its last value and valid_o=0.
- Latency: valid_o pulses exactly ReadLatency cycles after acceptance, for reads and writes alike. With ReadLatency=2, a second output register is added; both stages reset to 0.
- Write: only lanes with byte_en=1 are updated. A write with byte_en=0 still produces valid_o and returns the old word.
- Same-port read-during-write:
  - ReadFirst=0: data_o = old word with the enabled lanes replaced by write data.
  - ReadFirst=1: data_o = old word.
- Cross-port collision: both ports accepted, equal addresses, and at least one port writing.
  - Both writing: port A wins on overlapping enabled lanes; non-overlapping lanes from each port are written.
  - A reading port always returns the pre-cycle contents.
  - collision_o pulses for 1 cycle, exactly 1 cycle after the colliding access.
  - Two reads at the same address are not a collision.
- Out of range (addr >= Depth): the write is dropped and read data = 0. valid_o still pulses. With ENABLE_SIMULATION_ASSERTS defined and assert_on_i=1, $error is raised.
- FSM states IDLE and CLEAR:
  - IDLE -> CLEAR on clear_i=1. clear_i takes priority over same-cycle port accesses, which are dropped (no valid_o).
  - CLEAR: a counter runs 0..Depth-1 and writes one zero word per cycle; busy_o=1.
  - After writing Depth-1, the FSM returns to IDLE. busy_o is high for exactly Depth cycles, starting the cycle after clear_i.
  - clear_i during CLEAR is ignored; in-flight valid_o from earlier accepted accesses still completes.
- Reset mid-clear: the FSM returns to IDLE and busy_o=0 immediately. Words not yet cleared keep their prior contents.

Test Plan:
- Write A addr 3 = 0xBEEF with byte_en=11, then read B addr 3 (ReadLatency=1) -> b_valid_o one cycle after the read, b_data_o=0xBEEF; with ReadLatency=2 the result arrives 2 cycles after.
- addr 5 holds 0x1234; A writes 0xABCD with byte_en=01 -> word becomes 0x12CD; a_data_o=0x12CD when ReadFirst=0, 0x1234 when ReadFirst=1.
- Same cycle: A writes 0xAAAA (be=11) and B writes 0x5555 (be=11) to addr 2 -> memory=0xAAAA and collision_o=1 on the next cycle. Repeat with A be=10, B be=01 -> memory=0xAA55.
- Fill addr 0..7 with 0xFFFF, pulse clear_i -> busy_o high for 8 cycles; reads issued meanwhile give no valid_o; afterwards all 8 words read 0x0000.
- Start clear, assert rst_i on busy cycle 4 -> busy_o=0 and outputs 0 immediately; addr 0..3 read 0x0000, addr 4..7 read 0xFFFF.
- Depth=6: write 0x7777 to addr 7 then read addr 7 -> write dropped, a_valid_o=1, a_data_o=0, assert fires when assert_on_i=1.
